// File: rtl/rank_select.sv
// Sliding-window front end for the rank-order tracker: shifts samples into an
// N-deep window, then returns the entry whose tracker rank matches the request.
module rank_select #(
  parameter int data_bits = 8,
  parameter int N         = 7,
  parameter int rank_bits = $clog2(N) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [data_bits-1:0]           in_data,
  input  logic [rank_bits-1:0]           sel_rank,
  output logic [data_bits-1:0]           trk_new,
  output logic                           trk_en,
  output logic [data_bits*(N-1)-1:0]     trk_s,
  input  logic [rank_bits*N-1:0]         trk_ranks,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [data_bits-1:0]           out_data,
  output logic                           out_err
);

  localparam int fill_bits = $clog2(N + 1);
  localparam logic [fill_bits-1:0] fill_full = fill_bits'(N);
  localparam logic [fill_bits-1:0] fill_last = fill_bits'(N - 1);

  logic [data_bits-1:0] window_q [N];
  logic [data_bits-1:0] window_d [N];
  logic [fill_bits-1:0] fill_q, fill_d;
  logic                 pend_q, pend_d;
  logic [rank_bits-1:0] pend_rank_q, pend_rank_d;
  logic                 out_valid_q, out_valid_d;
  logic [data_bits-1:0] out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;

  logic                 accept;
  logic                 qualify;
  logic                 out_free;
  logic                 transfer;
  logic [data_bits-1:0] sel_data;
  logic                 sel_found;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !pend_q || out_free;
  assign accept   = in_valid && in_ready;
  assign qualify  = accept && (fill_q >= fill_last);
  assign transfer = pend_q && out_free;

  assign trk_new   = in_data;
  assign trk_en    = accept;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    trk_s = '0;
    for (int i = 0; i < N - 1; i++) begin
      trk_s[i*data_bits +: data_bits] = window_q[i];
    end
  end

  // Lowest index wins on duplicate ranks, i.e. the newest sample.
  always_comb begin
    sel_data  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!sel_found && (trk_ranks[i*rank_bits +: rank_bits] == pend_rank_q)) begin
        sel_found = 1'b1;
        sel_data  = window_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      window_d[i] = window_q[i];
    end
    fill_d      = fill_q;
    pend_d      = pend_q;
    pend_rank_d = pend_rank_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (accept) begin
      window_d[0] = in_data;
      for (int i = 1; i < N; i++) begin
        window_d[i] = window_q[i-1];
      end
      if (fill_q != fill_full) begin
        fill_d = fill_q + fill_bits'(1);
      end
    end

    // A qualifying accept on the same edge as a transfer re-arms pend.
    if (qualify) begin
      pend_d      = 1'b1;
      pend_rank_d = sel_rank;
    end else if (transfer) begin
      pend_d = 1'b0;
    end

    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_err_d   = !sel_found;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the window is reset deliberately; the tracker is cleared by the
      // same reset and its ranks must describe a known window afterwards.
      for (int i = 0; i < N; i++) begin
        window_q[i] <= '0;
      end
      fill_q      <= '0;
      pend_q      <= 1'b0;
      pend_rank_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        window_q[i] <= window_d[i];
      end
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      pend_rank_q <= pend_rank_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: doc/rank_select.md
Name: rank_select

Overview:
- Feeds and consumes the rank-order tracker in the adaptive rank-order filter.
- Holds the N-sample sliding window and drives the tracker's stored-sample bus and new-sample input. It strobes the tracker's update and reads back the N ranks.
- Returns the window sample whose rank equals a requested rank (e.g. median for N=7, sel_rank=4) over a valid/ready stream interface.
- Sits between the input sample stream and the filter output stage.

Parameters:
data_bits, 8, sample width
N, 7, window length (odd, >=3)
rank_bits, $clog2(N)+1, rank field width; must hold values 1..N

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  data_bits  input sample
sel_rank  in  rank_bits  requested rank (1=smallest), sampled on accept
trk_new  out  data_bits  new sample to tracker (combinational = in_data)
trk_en  out  1  tracker update enable, = in_valid & in_ready
trk_s  out  data_bits*(N-1)  window[0..N-2] to tracker, slice i = window[i]
trk_ranks  in  rank_bits*N  ranks from tracker, slice i = rank of window[i]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  data_bits  selected sample
out_err  out  1  no window entry matched the requested rank

Behaviour:
- Accept = in_valid & in_ready. On accept, the window shifts: window[0] <= in_data, window[i] <= window[i-1], and window[N-1] is dropped.
- trk_en equals accept. The tracker updates on the same edge, so trk_ranks is aligned with the window in the cycle after the accept.
- fill: saturating counter, 0..N, incremented on accept.
- pend (1 bit), pend_rank (rank_bits): a selection is owed.
  - Set on accept when fill+1 >= N, with pend_rank <= sel_rank.
  - Cleared on a transfer to the output register unless a new qualifying accept occurs on the same edge.
- Select (combinational, uses current window and trk_ranks):
  - Scan i=0..N-1; the lowest index with rank[i]==pend_rank wins, so the newest sample wins on duplicate ranks.
  - No match (pend_rank=0, >N, or a tracker fault) gives data=0, err=1.
- out_free = !out_valid | out_ready.
- Transfer when pend & out_free: out_data/out_err <= select result, out_valid <= 1.
- Else, if out_valid & out_ready: out_valid <= 0.
- in_ready = !pend | out_free (combinational). This gives full throughput of 1 sample/cycle with no stall.
- Accept and transfer on the same edge are legal. The transfer uses the pre-edge window/ranks belonging to the pending sample; the new sample becomes pending.
- Latency: a sample accepted at edge E gives out_valid high after edge E+1 if output is free.
- Warm-up: the first N-1 accepts produce no output. The N-th and every later accept produce exactly one result.
- Backpressure: out_data/out_err hold stable while out_valid & !out_ready. With pend=1, in_ready=0.
- in_data and sel_rank are ignored when not accepted.
- Reset (synchronous, any time including mid-stream):
  - window all 0, fill=0, pend=0, pend_rank=0.
  - out_valid=0, out_data=0, out_err=0.
  - The tracker is reset by the same rst; the in-flight result is discarded.
- in_ready is 1 in the first cycle after reset.
- No arithmetic beyond the fill counter; rank comparison is an unsigned equality compare on rank_bits.

Test Plan:
- Warm-up and median: N=7, sel_rank=4, out_ready=1.
  - Feed 10,50,30,70,20,60,40 back-to-back. No out_valid for the first 6.
  - After the 7th, out_data=40, out_err=0, exactly 2 cycles after its accept.
- Sliding: continue with 5, sel_rank=1 -> out_data=5. Then 90, sel_rank=7 -> out_data=90; 50 was dropped from the window.
- Backpressure: hold out_ready=0 with one result valid and one pending.
  - in_ready=0 and out_data stable for 5 cycles.
  - Release, and both results emerge in order on consecutive cycles with no loss.
- Invalid rank: with the window full, sel_rank=0 then sel_rank=8 -> out_data=0, out_err=1 for each. The next sel_rank=4 gives out_err=0.
- Duplicates: window all 25, sel_rank=3 -> out_data=25, out_err=0. Window[0] is chosen when ranks repeat.
- Reset mid-stream: assert rst for 1 cycle while pend=1 and out_valid=1.
  - Next cycle: out_valid=0, in_ready=1.
  - The following 6 accepts produce no output; the 7th does.
